// File: rtl/keypad_pkg.sv
// keypad_pkg: key actions, scan states and the default 4x3 multi-tap key table
package keypad_pkg;
  typedef enum logic [2:0] {KA_NOP, KA_LETTER, KA_SUBMIT_LETTER, KA_CLEAR, KA_SUBMIT_WORD} key_action_e;
  typedef enum logic [1:0] {SCAN, DEB_PRESS, DEB_RELEASE} scan_state_e;
  typedef struct packed {
    key_action_e action;
    logic [7:0]  base;
    logic [2:0]  count;
  } key_info_t;
  localparam int TABLE_ROWS = 4;
  localparam int TABLE_COLS = 3;
  // Row-major table; key 0 ('1') and anything outside the table is a no-op.
  function automatic key_info_t key_decode(input logic [3:0] key);
    case (key)
      4'd1:    key_decode = '{KA_LETTER, 8'h41, 3'd3};
      4'd2:    key_decode = '{KA_LETTER, 8'h44, 3'd3};
      4'd3:    key_decode = '{KA_LETTER, 8'h47, 3'd3};
      4'd4:    key_decode = '{KA_LETTER, 8'h4A, 3'd3};
      4'd5:    key_decode = '{KA_LETTER, 8'h4D, 3'd3};
      4'd6:    key_decode = '{KA_LETTER, 8'h50, 3'd4};
      4'd7:    key_decode = '{KA_LETTER, 8'h54, 3'd3};
      4'd8:    key_decode = '{KA_LETTER, 8'h57, 3'd4};
      4'd9:    key_decode = '{KA_SUBMIT_LETTER, 8'h00, 3'd0};
      4'd10:   key_decode = '{KA_CLEAR, 8'h00, 3'd0};
      4'd11:   key_decode = '{KA_SUBMIT_WORD, 8'h00, 3'd0};
      default: key_decode = '{KA_NOP, 8'h00, 3'd0};
    endcase
  endfunction
endpackage

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: row synchroniser plus press/release debounce FSM producing a key-accept strobe
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ROWS-1:0]                       i_row,
  output logic                                  o_idle,
  output logic                                  o_accept,
  output logic                                  o_multi,
  output logic [$clog2(ROWS>1?ROWS:2)-1:0]      o_row_idx
);
  localparam int RW = $clog2(ROWS > 1 ? ROWS : 2);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [ROWS-1:0] r_meta, r_rs, r_pat, w_pat_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  scan_state_e     r_state, w_state_n;
  // Two-flop synchroniser and FSM state/counter registers
  always_ff @(posedge clk)
    if (rst) begin
      r_meta  <= '0;
      r_rs    <= '0;
      r_pat   <= '0;
      r_cnt   <= '0;
      r_state <= SCAN;
    end else begin
      r_meta  <= i_row;
      r_rs    <= r_meta;
      r_pat   <= w_pat_n;
      r_cnt   <= w_cnt_n;
      r_state <= w_state_n;
    end
  // Next state: a press must hold one pattern for DEBOUNCE_CYCLES samples, a release must stay all-zero as long
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pat_n   = r_pat;
    o_accept  = 1'b0;
    case (r_state)
      SCAN:
        if (r_rs != '0) begin
          w_state_n = DEB_PRESS;
          w_pat_n   = r_rs;
          w_cnt_n   = CW'(1);
        end
      DEB_PRESS:
        if (r_rs == '0) begin
          w_state_n = SCAN;
          w_cnt_n   = '0;
        end else if (r_rs != r_pat) begin
          w_pat_n = r_rs;
          w_cnt_n = CW'(1);
        end else if (r_cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
          o_accept  = 1'b1;
          w_state_n = DEB_RELEASE;
          w_cnt_n   = '0;
        end else w_cnt_n = r_cnt + 1'b1;
      DEB_RELEASE:
        if (r_rs != '0) w_cnt_n = '0;
        else if (r_cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
          w_state_n = SCAN;
          w_cnt_n   = '0;
        end else w_cnt_n = r_cnt + 1'b1;
      default: w_state_n = SCAN;
    endcase
  end
  // Pattern classification: not one-hot is an error, otherwise report the active row
  always_comb begin
    o_idle    = (r_state == SCAN) && (r_rs == '0);
    o_multi   = (r_pat & (r_pat - 1'b1)) != '0;
    o_row_idx = '0;
    for (int i = 0; i < ROWS; i++) if (r_pat[i]) o_row_idx = RW'(i);
  end
endmodule

// File: rtl/multitap_keypad_scanner.sv
// multitap_keypad_scanner: column scan, multi-tap letter entry and letter/word strobes
module multitap_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS             = 4,
  parameter int COLS             = 3,
  parameter int SCAN_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int MULTITAP_TIMEOUT = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            pending,
  output logic [7:0]      pending_char,
  output logic            letter_valid,
  output logic [7:0]      letter,
  output logic            word_submit,
  output logic            error
);
  localparam int RW = $clog2(ROWS > 1 ? ROWS : 2);
  localparam int CW = $clog2(COLS > 1 ? COLS : 2);
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int TW = $clog2(MULTITAP_TIMEOUT + 1);
  logic          w_idle, w_accept, w_multi, w_in_table, w_same, w_ok;
  logic          w_letter, w_submit_ok, w_word_ok, w_clear, w_err;
  logic [RW-1:0] w_row_idx;
  logic [CW-1:0] r_col_idx;
  logic [SW-1:0] r_scan_cnt;
  logic [TW-1:0] r_tmo;
  logic [3:0]    w_key, r_last;
  logic [2:0]    r_tap, w_tap_inc, w_tap_n;
  key_info_t     w_info;
  keypad_debouncer #(.ROWS(ROWS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .i_row     (row),
    .o_idle    (w_idle),
    .o_accept  (w_accept),
    .o_multi   (w_multi),
    .o_row_idx (w_row_idx)
  );
  assign col = COLS'(1) << r_col_idx;
  // Rotate the driven column only while idle, so a detected press freezes it
  always_ff @(posedge clk)
    if (rst) begin
      r_col_idx  <= '0;
      r_scan_cnt <= '0;
    end else if (w_idle) begin
      r_scan_cnt <= (r_scan_cnt == SW'(SCAN_CYCLES - 1)) ? '0 : r_scan_cnt + 1'b1;
      if (r_scan_cnt == SW'(SCAN_CYCLES - 1)) r_col_idx <= (r_col_idx == CW'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
    end
  // Key decode and action qualification; keys outside the default table fall back to key 0 (no-op)
  always_comb begin
    w_in_table  = (int'(w_row_idx) < TABLE_ROWS) && (int'(r_col_idx) < TABLE_COLS);
    w_key       = w_in_table ? 4'(int'(w_row_idx) * TABLE_COLS + int'(r_col_idx)) : 4'd0;
    w_info      = key_decode(w_key);
    w_ok        = w_accept && !w_multi;
    w_same      = (w_key == r_last) && pending && (r_tmo < TW'(MULTITAP_TIMEOUT));
    w_tap_inc   = (r_tap + 3'd1 == w_info.count) ? 3'd0 : r_tap + 3'd1;
    w_tap_n     = w_same ? w_tap_inc : 3'd0;
    w_letter    = w_ok && (w_info.action == KA_LETTER);
    w_submit_ok = w_ok && (w_info.action == KA_SUBMIT_LETTER) && pending;
    w_word_ok   = w_ok && (w_info.action == KA_SUBMIT_WORD) && !pending;
    w_clear     = w_ok && (w_info.action == KA_CLEAR);
    w_err       = w_accept && (w_multi || (w_info.action == KA_SUBMIT_LETTER && !pending) ||
                               (w_info.action == KA_SUBMIT_WORD && pending));
  end
  // Multi-tap staging, commit and one-cycle strobes
  always_ff @(posedge clk)
    if (rst) begin
      pending      <= 1'b0;
      pending_char <= 8'h00;
      letter_valid <= 1'b0;
      letter       <= 8'h00;
      word_submit  <= 1'b0;
      error        <= 1'b0;
      r_tmo        <= '0;
      r_last       <= '0;
      r_tap        <= '0;
    end else begin
      letter_valid <= w_submit_ok;
      word_submit  <= w_word_ok;
      error        <= w_err;
      r_tmo        <= w_letter ? '0 : (r_tmo == TW'(MULTITAP_TIMEOUT)) ? r_tmo : r_tmo + 1'b1;
      if (w_letter) begin
        r_last       <= w_key;
        r_tap        <= w_tap_n;
        pending      <= 1'b1;
        pending_char <= w_info.base + {5'd0, w_tap_n};
      end
      if (w_submit_ok) letter <= pending_char;
      if (w_submit_ok || w_clear) begin
        pending      <= 1'b0;
        pending_char <= 8'h00;
      end
    end
endmodule
